// File: rtl/instr_mem_prog.sv
// Loadable instruction memory: zero-filled after every reset release, serves registered
// one-cycle fetches with fault flagging, and is programmed through a byte-wide stream port.
module instr_mem_prog #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 32,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_valid,
   output logic [DATA_W-1:0] instruction,
   output logic              fetch_err,
   output logic              busy,
   input  logic              prog_en,
   input  logic              prog_byte_valid,
   input  logic [7:0]        prog_byte,
   output logic              prog_ready,
   output logic              prog_done,
   output logic [IDX_W:0]    prog_words,
   output logic              prog_ovf
);

   localparam int BPW   = DATA_W / 8;
   localparam int BC_W  = $clog2(BPW + 1);
   localparam int LIM_W = ADDR_W + 1;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_RUN   = 2'd1,
      ST_LOAD  = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   state_t              state_r, state_s;
   logic [IDX_W-1:0]    clr_ptr_r, clr_ptr_s;
   logic [IDX_W:0]      wr_ptr_r, wr_ptr_s;
   logic [BC_W-1:0]     byte_cnt_r, byte_cnt_s;
   logic [DATA_W-1:0]   asm_r, asm_s;
   logic                ovf_r, ovf_s;
   logic                done_r, done_s;
   logic [IDX_W:0]      words_r, words_s;
   logic                valid_r, valid_s;
   logic [DATA_W-1:0]   instr_r, instr_s;
   logic                err_r, err_s;
   logic                ready_r, ready_s;
   logic                busy_r, busy_s;

   logic                we_s;
   logic [IDX_W-1:0]    wa_s;
   logic [DATA_W-1:0]   wd_s;
   logic [DATA_W-1:0]   rd_word_s;

   logic [DATA_W-1:0]   mem [DEPTH];

   // Misaligned address or beyond the last word of the array.
   function automatic logic addr_fault(input logic [ADDR_W-1:0] a);
      logic [LIM_W-1:0] lim;
      lim = LIM_W'(DEPTH) << 2;
      return (a[1:0] != 2'b00) || ({1'b0, a} >= lim);
   endfunction

   assign rd_word_s = mem[fetch_addr[IDX_W+1:2]];

   // Next-state, write-port and output-register logic.
   always_comb begin
      state_s    = state_r;
      clr_ptr_s  = clr_ptr_r;
      wr_ptr_s   = wr_ptr_r;
      byte_cnt_s = byte_cnt_r;
      asm_s      = asm_r;
      ovf_s      = ovf_r;
      done_s     = 1'b0;
      words_s    = words_r;
      valid_s    = 1'b0;
      instr_s    = instr_r;
      err_s      = err_r;
      we_s       = 1'b0;
      wa_s       = '0;
      wd_s       = '0;

      case (state_r)
         ST_CLEAR: begin
            we_s      = 1'b1;
            wa_s      = clr_ptr_r;
            wd_s      = '0;
            clr_ptr_s = clr_ptr_r + IDX_W'(1);
            if (clr_ptr_r == IDX_W'(DEPTH - 1)) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_CLEAR;
            end
         end

         ST_RUN: begin
            if (fetch_req) begin
               valid_s = 1'b1;
               if (addr_fault(fetch_addr)) begin
                  err_s   = 1'b1;
                  instr_s = '0;
               end else begin
                  err_s   = 1'b0;
                  instr_s = rd_word_s;
               end
            end else begin
               valid_s = 1'b0;
            end
            if (prog_en) begin
               state_s    = ST_LOAD;
               wr_ptr_s   = '0;
               byte_cnt_s = '0;
               ovf_s      = 1'b0;
            end else begin
               state_s = ST_RUN;
            end
         end

         ST_LOAD: begin
            if (!prog_en) begin
               if (byte_cnt_r == '0) begin
                  state_s = ST_RUN;
                  done_s  = 1'b1;
                  words_s = wr_ptr_r;
               end else begin
                  state_s = ST_FLUSH;
               end
            end else if (prog_byte_valid) begin
               state_s = ST_LOAD;
               if (wr_ptr_r[IDX_W]) begin
                  ovf_s = 1'b1;
               end else begin
                  asm_s = (asm_r << 8) | DATA_W'(prog_byte);
                  if (byte_cnt_r == BC_W'(BPW - 1)) begin
                     we_s       = 1'b1;
                     wa_s       = wr_ptr_r[IDX_W-1:0];
                     wd_s       = asm_s;
                     wr_ptr_s   = wr_ptr_r + (IDX_W + 1)'(1);
                     byte_cnt_s = '0;
                  end else begin
                     byte_cnt_s = byte_cnt_r + BC_W'(1);
                  end
               end
            end else begin
               state_s = ST_LOAD;
            end
         end

         ST_FLUSH: begin
            // Bytes sit right-justified in the assembler; shift them up and zero-pad the tail.
            we_s       = 1'b1;
            wa_s       = wr_ptr_r[IDX_W-1:0];
            wd_s       = asm_r << {BC_W'(BPW) - byte_cnt_r, 3'b000};
            wr_ptr_s   = wr_ptr_r + (IDX_W + 1)'(1);
            byte_cnt_s = '0;
            state_s    = ST_RUN;
            done_s     = 1'b1;
            words_s    = wr_ptr_r + (IDX_W + 1)'(1);
         end

         default: begin
            state_s = ST_CLEAR;
         end
      endcase

      ready_s = (state_s == ST_LOAD) && !wr_ptr_s[IDX_W];
      busy_s  = (state_s != ST_RUN);
   end

   // State, pointers, assembler and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_CLEAR;
         clr_ptr_r  <= '0;
         wr_ptr_r   <= '0;
         byte_cnt_r <= '0;
         asm_r      <= '0;
         ovf_r      <= 1'b0;
         done_r     <= 1'b0;
         words_r    <= '0;
         valid_r    <= 1'b0;
         instr_r    <= '0;
         err_r      <= 1'b0;
         ready_r    <= 1'b0;
         busy_r     <= 1'b1;
      end else begin
         state_r    <= state_s;
         clr_ptr_r  <= clr_ptr_s;
         wr_ptr_r   <= wr_ptr_s;
         byte_cnt_r <= byte_cnt_s;
         asm_r      <= asm_s;
         ovf_r      <= ovf_s;
         done_r     <= done_s;
         words_r    <= words_s;
         valid_r    <= valid_s;
         instr_r    <= instr_s;
         err_r      <= err_s;
         ready_r    <= ready_s;
         busy_r     <= busy_s;
      end
   end

   // Single write port shared by clear, load and flush; contents survive reset.
   always_ff @(posedge clk) begin
      if (we_s) begin
         mem[wa_s] <= wd_s;
      end
   end

   assign fetch_valid = valid_r;
   assign instruction = instr_r;
   assign fetch_err   = err_r;
   assign busy        = busy_r;
   // Gated by prog_en so a byte offered as prog_en falls is never handshaken.
   assign prog_ready  = ready_r & prog_en;
   assign prog_done   = done_r;
   assign prog_words  = words_r;
   assign prog_ovf    = ovf_r;

endmodule

// File: tb/tb_instr_mem_prog.sv
// Directed self-checking bench for instr_mem_prog: clear, load, flush, fetch faults,
// overflow and reset during a load.
module tb_instr_mem_prog;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_valid;
   logic [31:0] instruction;
   logic        fetch_err;
   logic        busy;
   logic        prog_en;
   logic        prog_byte_valid;
   logic [7:0]  prog_byte;
   logic        prog_ready;
   logic        prog_done;
   logic [8:0]  prog_words;
   logic        prog_ovf;

   int total  = 0;
   int passed = 0;

   logic [7:0] pb [0:1099];

   typedef struct packed {
      logic        req;
      logic [31:0] addr;
      logic        v;
      logic [31:0] instr;
      logic        err;
   } vec_t;

   vec_t vecs [11];

   always #5 clk = ~clk;

   instr_mem_prog dut (
      .clk(clk),
      .reset(reset),
      .fetch_req(fetch_req),
      .fetch_addr(fetch_addr),
      .fetch_valid(fetch_valid),
      .instruction(instruction),
      .fetch_err(fetch_err),
      .busy(busy),
      .prog_en(prog_en),
      .prog_byte_valid(prog_byte_valid),
      .prog_byte(prog_byte),
      .prog_ready(prog_ready),
      .prog_done(prog_done),
      .prog_words(prog_words),
      .prog_ovf(prog_ovf)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_clear(input string tag);
      int   n;
      logic quiet;
      n = 0;
      quiet = 1'b1;
      while (busy && n < 300) begin
         if (fetch_valid || prog_done || prog_ready) quiet = 1'b0;
         tick;
         n++;
      end
      chk({tag, "_len"}, n, 256);
      chk({tag, "_quiet"}, {31'd0, quiet}, 32'd1);
      chk({tag, "_end_valid"}, {31'd0, fetch_valid}, 32'd0);
   endtask

   task automatic do_fetch(input string name, input logic [31:0] addr,
                           input logic [31:0] exp_instr, input logic exp_err);
      fetch_req  = 1'b1;
      fetch_addr = addr;
      tick;
      fetch_req  = 1'b0;
      chk({name, "_valid"}, {31'd0, fetch_valid}, 32'd1);
      chk({name, "_instr"}, instruction, exp_instr);
      chk({name, "_err"}, {31'd0, fetch_err}, {31'd0, exp_err});
   endtask

   task automatic load(input string tag, input int n, input bit fetch_at_entry,
                       input logic [31:0] entry_instr, input bit expect_flush,
                       input logic [31:0] exp_words, input logic exp_ovf);
      logic bad;
      bad = 1'b0;
      prog_en = 1'b1;
      if (fetch_at_entry) begin
         fetch_req  = 1'b1;
         fetch_addr = 32'h0;
      end
      tick;
      if (fetch_at_entry) begin
         chk({tag, "_entry_valid"}, {31'd0, fetch_valid}, 32'd1);
         chk({tag, "_entry_instr"}, instruction, entry_instr);
      end
      for (int i = 0; i < n; i++) begin
         prog_byte_valid = 1'b1;
         prog_byte       = pb[i];
         if (i == 0)    chk({tag, "_ready_first"}, {31'd0, prog_ready}, 32'd1);
         if (i == 1023) chk({tag, "_ready_last"}, {31'd0, prog_ready}, 32'd1);
         if (i == 1024) chk({tag, "_ready_full"}, {31'd0, prog_ready}, 32'd0);
         tick;
         if (fetch_valid) bad = 1'b1;
      end
      prog_byte_valid = 1'b1;
      prog_byte       = 8'hAA;
      prog_en         = 1'b0;
      fetch_req       = 1'b0;
      #1;
      chk({tag, "_ready_drop"}, {31'd0, prog_ready}, 32'd0);
      chk({tag, "_fetch_ignored"}, {31'd0, bad}, 32'd0);
      tick;
      if (expect_flush) begin
         chk({tag, "_flush_busy"}, {31'd0, busy}, 32'd1);
         chk({tag, "_flush_nodone"}, {31'd0, prog_done}, 32'd0);
         tick;
      end
      prog_byte_valid = 1'b0;
      chk({tag, "_done"}, {31'd0, prog_done}, 32'd1);
      chk({tag, "_words"}, {23'd0, prog_words}, exp_words);
      chk({tag, "_ovf"}, {31'd0, prog_ovf}, {31'd0, exp_ovf});
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      tick;
      chk({tag, "_done_pulse"}, {31'd0, prog_done}, 32'd0);
   endtask

   initial begin
      reset           = 1'b0;
      fetch_req       = 1'b0;
      fetch_addr      = 32'h0;
      prog_en         = 1'b0;
      prog_byte_valid = 1'b0;
      prog_byte       = 8'h00;

      vecs[0]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h2009_000A, 1'b0};
      vecs[1]  = '{1'b1, 32'h0000_0004, 1'b1, 32'h2000_0000, 1'b0};
      vecs[2]  = '{1'b0, 32'h0000_0008, 1'b0, 32'h2000_0000, 1'b0};
      vecs[3]  = '{1'b1, 32'h0000_0002, 1'b1, 32'h0000_0000, 1'b1};
      vecs[4]  = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1};
      vecs[5]  = '{1'b1, 32'h0000_0400, 1'b1, 32'h0000_0000, 1'b1};
      vecs[6]  = '{1'b1, 32'h0000_0004, 1'b1, 32'h2000_0000, 1'b0};
      vecs[7]  = '{1'b1, 32'h0000_03FC, 1'b1, 32'h0000_0000, 1'b0};
      vecs[8]  = '{1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_0000, 1'b1};
      vecs[9]  = '{1'b1, 32'h0000_0401, 1'b1, 32'h0000_0000, 1'b1};
      vecs[10] = '{1'b1, 32'h0000_0000, 1'b1, 32'h2009_000A, 1'b0};

      repeat (3) tick;
      chk("rst_busy", {31'd0, busy}, 32'd1);
      chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
      chk("rst_instr", instruction, 32'd0);
      chk("rst_err", {31'd0, fetch_err}, 32'd0);
      chk("rst_ready", {31'd0, prog_ready}, 32'd0);
      chk("rst_done", {31'd0, prog_done}, 32'd0);
      chk("rst_words", {23'd0, prog_words}, 32'd0);
      chk("rst_ovf", {31'd0, prog_ovf}, 32'd0);

      reset      = 1'b1;
      fetch_req  = 1'b1;
      fetch_addr = 32'h0;
      wait_clear("clear1");
      do_fetch("first_fetch", 32'h10, 32'h0, 1'b0);

      pb[0] = 8'h20; pb[1] = 8'h02; pb[2] = 8'h00; pb[3] = 8'h48;
      pb[4] = 8'hFC; pb[5] = 8'h00; pb[6] = 8'h00; pb[7] = 8'h00;
      load("load1", 8, 1'b0, 32'h0, 1'b0, 32'd2, 1'b0);
      do_fetch("l1_w0", 32'h0, 32'h2002_0048, 1'b0);
      do_fetch("l1_w1", 32'h4, 32'hFC00_0000, 1'b0);

      pb[0] = 8'h20; pb[1] = 8'h09; pb[2] = 8'h00; pb[3] = 8'h0A; pb[4] = 8'h20;
      load("load2", 5, 1'b1, 32'h2002_0048, 1'b1, 32'd2, 1'b0);

      for (int i = 0; i < 11; i++) begin
         fetch_req  = vecs[i].req;
         fetch_addr = vecs[i].addr;
         tick;
         chk($sformatf("vec%0d_valid", i), {31'd0, fetch_valid}, {31'd0, vecs[i].v});
         chk($sformatf("vec%0d_instr", i), instruction, vecs[i].instr);
         chk($sformatf("vec%0d_err", i), {31'd0, fetch_err}, {31'd0, vecs[i].err});
      end
      fetch_req = 1'b0;
      tick;

      for (int i = 0; i < 1025; i++) pb[i] = i[7:0];
      load("ovf", 1025, 1'b0, 32'h0, 1'b0, 32'd256, 1'b1);
      do_fetch("ovf_w0", 32'h0, 32'h0001_0203, 1'b0);
      do_fetch("ovf_w255", 32'h3FC, 32'hFCFD_FEFF, 1'b0);
      do_fetch("ovf_oob", 32'h400, 32'h0, 1'b1);

      prog_en = 1'b1;
      tick;
      for (int i = 0; i < 6; i++) begin
         prog_byte_valid = 1'b1;
         prog_byte       = 8'h11 + 8'(i);
         tick;
      end
      #2;
      reset           = 1'b0;
      prog_en         = 1'b0;
      prog_byte_valid = 1'b0;
      #1;
      chk("mid_rst_busy", {31'd0, busy}, 32'd1);
      chk("mid_rst_done", {31'd0, prog_done}, 32'd0);
      chk("mid_rst_ready", {31'd0, prog_ready}, 32'd0);
      chk("mid_rst_words", {23'd0, prog_words}, 32'd0);
      tick;
      reset = 1'b1;
      wait_clear("clear2");
      chk("clear2_no_done", {31'd0, prog_done}, 32'd0);
      do_fetch("clr2_w0", 32'h0, 32'h0, 1'b0);
      do_fetch("clr2_w255", 32'h3FC, 32'h0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
